array_access_arbiter: RTL
=========================

Name: array_access_arbiter

Overview:
Controller placed in front of the array_dataflow memory (synchronous write, combinational read). After reset it sequences a full clear of the array. It then shares the single write/read port between two requesters, with round-robin arbitration and a valid/ready handshake. Read data returns registered, one cycle after the grant.

Parameters:
WIDTH, 8, data word width; must match the memory.
DEPTH, 4, number of words; power of two, >= 2; elaboration error otherwise.
INIT_VALUE, 0, word written to every location during the clear sequence.
(ADDR = $clog2(DEPTH), derived localparam, not overridable.)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  2  per-requester request valid (bit i = requester i)
req_ready  out  2  per-requester grant; at most one bit high per cycle
req_we  in  2  1 = write, 0 = read, per requester
req_addr  in  2*ADDR  requester i address in bits [i*ADDR +: ADDR]
req_wdata  in  2*WIDTH  requester i write data in bits [i*WIDTH +: WIDTH]
rsp_valid  out  2  one-cycle pulse: read data for requester i is on rsp_rdata
rsp_rdata  out  WIDTH  registered read data
init_done  out  1  high once the clear sequence has completed
mem_write_en  out  1  to memory write_en
mem_write_addr  out  ADDR  to memory write_addr
mem_write_data  out  WIDTH  to memory write_data
mem_read_addr  out  ADDR  to memory read_addr
mem_read_data  in  WIDTH  from memory read_data (combinational)

Behaviour:
- State machine states: INIT and RUN. A cycle with rst=1 loads INIT, init_ptr=0, last_grant=1, rsp_valid=0, rsp_rdata=0 and init_done=0.
- While rst=1, req_ready=0 and mem_write_en=0.
- INIT:
  - Each cycle drives mem_write_en=1, mem_write_addr=init_ptr, mem_write_data=INIT_VALUE; init_ptr increments.
  - On the cycle init_ptr==DEPTH-1, next state is RUN. INIT lasts exactly DEPTH cycles.
  - init_done rises on the first RUN cycle and stays high until the next reset.
  - req_ready=0 throughout INIT.
- RUN, arbitration (combinational from req_valid and last_grant):
  - One requester valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - last_grant updates only on cycles with a grant. With last_grant reset to 1, requester 0 wins the first tie.
- req_ready is the one-hot grant. A transfer occurs when req_valid[i] & req_ready[i].
- Requester rule: addr, we and wdata are held stable while valid && !ready. Dropping valid before ready is permitted, and no transfer occurs.
- Write transfer:
  - mem_write_en=1, mem_write_addr/data taken from the granted requester in the same cycle.
  - Memory updates at that clock edge; there is no response.
- Read transfer:
  - mem_read_addr = granted address, same cycle. mem_read_data is captured into rsp_rdata at the edge.
  - rsp_valid[i]=1 for exactly the next cycle. Read latency is 1 cycle, throughput is 1 transfer per cycle.
- When there is no read grant, mem_read_addr holds its previous value and rsp_rdata holds.
- When there is no transfer, mem_write_en=0 and rsp_valid=0.
- Read-after-write to the same address in consecutive cycles returns the new data.
- rst asserted mid-operation: any in-flight rsp_valid is suppressed. The FSM returns to INIT and the array is cleared again.

Decomposition:
- Package array_ctrl_pkg:
  - typedef ctrl_state_t {INIT, RUN}
  - localparam NUM_REQ=2
- Sub-module rr_arbiter2: inputs req[1:0] and last_grant; outputs one-hot grant[1:0]; combinational.
- The top level holds the FSM, init_ptr, last_grant, the response register and the port muxing.

Test Plan:
1. Apply rst for 2 cycles, then release with DEPTH=4 and INIT_VALUE=8'h5A. Required: mem_write_en high for exactly 4 cycles at addresses 0,1,2,3; init_done=1 on cycle 5; subsequent reads of all addresses return 8'h5A.
2. Requester 0 writes 8'h22 to addr 1, next cycle reads addr 1. Required: rsp_valid=2'b01 one cycle after the read grant, rsp_rdata=8'h22.
3. Both requesters hold reads (addrs 2 and 3) valid for 4 cycles. Required: grants alternate 0,1,0,1; rsp_valid pulses 01,10,01,10 with matching data.
4. Requester 1 alone issues back-to-back reads for 3 cycles. Required: req_ready=2'b10 every cycle; 3 consecutive rsp_valid pulses, no bubbles.
5. Both requesters write the same addr 0 (8'h11 and 8'h44) simultaneously, then read. Required: requester 0's write is granted first and requester 1's second; the final readback is 8'h44.
6. Assert rst for 1 cycle while a read is granted in RUN. Required: no rsp_valid the following cycle, init_done drops to 0, the 4-cycle clear repeats, and readback is INIT_VALUE.

Source files
------------

// File: rtl/array_ctrl_pkg.sv
// array_ctrl_pkg: shared types and constants for the array access controller
package array_ctrl_pkg;
    typedef enum logic {INIT, RUN} ctrl_state_t;
    localparam int NUM_REQ = 2;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter, ties go to the requester not granted last
module rr_arbiter2
    import array_ctrl_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last_grant,
    output logic [NUM_REQ-1:0] grant
);
    always_comb begin
        grant[0] = req[0] & (~req[1] | last_grant);
        grant[1] = req[1] & (~req[0] | ~last_grant);
    end
endmodule

// File: rtl/array_access_arbiter.sv
// array_access_arbiter: clears the array after reset, then shares its port between two requesters
module array_access_arbiter
    import array_ctrl_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 4,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0,
    localparam int              ADDR       = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR-1:0]   req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [WIDTH-1:0]          rsp_rdata,
    output logic                      init_done,
    output logic                      mem_write_en,
    output logic [ADDR-1:0]           mem_write_addr,
    output logic [WIDTH-1:0]          mem_write_data,
    output logic [ADDR-1:0]           mem_read_addr,
    input  logic [WIDTH-1:0]          mem_read_data
);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("array_access_arbiter: DEPTH must be a power of two >= 2");
    end

    ctrl_state_t          state;
    logic [ADDR-1:0]      init_ptr;
    logic [ADDR-1:0]      rd_addr_q;
    logic                 last_grant;
    logic [NUM_REQ-1:0]   grant;
    logic                 run;
    logic                 sel;
    logic                 gnt_we;
    logic [ADDR-1:0]      gnt_addr;
    logic [WIDTH-1:0]     gnt_wdata;
    logic                 rd_xfer;
    logic                 wr_xfer;

    rr_arbiter2 u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // The grant is only ever raised for a valid requester, so ready doubles as the transfer strobe
    always_comb begin
        run            = (state == RUN) && !rst;
        req_ready      = run ? grant : '0;
        sel            = req_ready[1];
        gnt_we         = sel ? req_we[1] : req_we[0];
        gnt_addr       = sel ? req_addr[ADDR +: ADDR] : req_addr[0 +: ADDR];
        gnt_wdata      = sel ? req_wdata[WIDTH +: WIDTH] : req_wdata[0 +: WIDTH];
        rd_xfer        = |req_ready && !gnt_we;
        wr_xfer        = |req_ready && gnt_we;
        mem_write_en   = !rst && (state == INIT || wr_xfer);
        mem_write_addr = (state == INIT) ? init_ptr : gnt_addr;
        mem_write_data = (state == INIT) ? INIT_VALUE : gnt_wdata;
        mem_read_addr  = rd_xfer ? gnt_addr : rd_addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= INIT;
            init_ptr   <= '0;
            last_grant <= 1'b1;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            init_done  <= 1'b0;
            rd_addr_q  <= '0;
        end else begin
            rsp_valid <= rd_xfer ? req_ready : '0;
            if (rd_xfer) begin
                rsp_rdata <= mem_read_data;
                rd_addr_q <= gnt_addr;
            end
            if (|req_ready)
                last_grant <= sel;
            if (state == INIT) begin
                init_ptr <= init_ptr + 1'b1;
                if (init_ptr == ADDR'(DEPTH - 1)) begin
                    state     <= RUN;
                    init_done <= 1'b1;
                end
            end
        end
    end
endmodule
